// File: rtl/rmii_rx_fifo_if.sv
// Read side of the RMII receive FIFO: show-ahead head entry plus its pop handshake.
// The head entry is presented while rd_valid=1 and is popped on any rising clock
// edge where rd_valid && rd_ready; rd_ready may be held high while rd_valid=0.
interface rmii_rx_fifo_if #(
    parameter int WORD_W = 32
) ();
    localparam int BW = $clog2(WORD_W / 8 + 1);

    logic [WORD_W-1:0] rd_data;
    logic [BW-1:0]     rd_bytes;
    logic              rd_last;
    logic              rd_err;
    logic              rd_valid;
    logic              rd_ready;

    modport master (
        output rd_data,
        output rd_bytes,
        output rd_last,
        output rd_err,
        output rd_valid,
        input  rd_ready
    );

    modport slave (
        input  rd_data,
        input  rd_bytes,
        input  rd_last,
        input  rd_err,
        input  rd_valid,
        output rd_ready
    );
endinterface

// File: rtl/rmii_rx_fifo.sv
// RMII receive path: optional preamble/SFD hunt, dibit-to-word deserialiser and a
// show-ahead word FIFO tagged with frame-end/byte-count/error information.
module rmii_rx_fifo #(
    parameter int WORD_W = 32,
    parameter int DEPTH  = 8,
    parameter bit SFD_EN = 1'b1
) (
    input  logic                       clk_25_mhz,
    input  logic                       rst_n,
    input  logic [1:0]                 rx_d,
    input  logic                       crs_dv,
    input  logic                       rx_er,
    rmii_rx_fifo_if.master             rd,
    output logic [$clog2(DEPTH+1)-1:0] fifo_level,
    output logic                       overflow,
    input  logic                       ovf_clr,
    output logic [15:0]                frame_cnt,
    output logic [1:0]                 dbg_state,
    output logic                       dbg_pending_term
);
    localparam int HALF = WORD_W / 2;
    localparam int CW   = $clog2(HALF);
    localparam int BW   = $clog2(WORD_W / 8 + 1);
    localparam int AW   = $clog2(DEPTH);
    localparam int LW   = $clog2(DEPTH + 1);

    localparam logic [CW-1:0] CNT_LAST   = CW'(HALF - 1);
    localparam logic [BW-1:0] FULL_BYTES = BW'(WORD_W / 8);
    localparam logic [LW-1:0] DEPTH_L    = LW'(DEPTH);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        PREAMBLE = 2'd1,
        DATA     = 2'd2,
        DROP     = 2'd3
    } state_t;

    state_t state_q, state_d;

    logic [WORD_W-1:0] sr;
    logic [CW-1:0]     cnt;
    logic [1:0]        pre_cnt;
    logic              frame_err;
    logic              in_frame;
    logic              pending_term;
    logic              crs_dv_q;

    logic [WORD_W-1:0] mem_data  [DEPTH];
    logic [BW-1:0]     mem_bytes [DEPTH];
    logic              mem_last  [DEPTH];
    logic              mem_err   [DEPTH];
    logic [AW-1:0]     wr_ptr, rd_ptr;
    logic [LW-1:0]     level;

    logic              valid;
    logic              pop;
    logic              frame_start;
    logic              capture;
    logic              word_done;
    logic              term_now;
    logic              push_req;
    logic [WORD_W-1:0] push_data;
    logic [BW-1:0]     push_bytes;
    logic              push_last;
    logic              push_err;
    logic              accept;
    logic              reject;
    logic              start_drop;
    logic              set_pending;
    logic              ovf_set;

    assign valid       = (level != '0);
    assign pop         = valid && rd.rd_ready;
    // A frame only starts on a genuine crs_dv rising edge; crs_dv_q resets high.
    assign frame_start = crs_dv && !crs_dv_q;

    always_comb begin
        state_d     = state_q;
        capture     = 1'b0;
        word_done   = 1'b0;
        term_now    = 1'b0;
        push_req    = 1'b0;
        push_data   = '0;
        push_bytes  = '0;
        push_last   = 1'b0;
        push_err    = 1'b0;
        start_drop  = 1'b0;
        set_pending = 1'b0;
        accept      = 1'b0;
        reject      = 1'b0;

        if (pending_term) begin
            push_req  = 1'b1;
            push_last = 1'b1;
            push_err  = 1'b1;
        end

        case (state_q)
            IDLE: begin
                if (frame_start) begin
                    if (pending_term) begin
                        state_d    = DROP;
                        start_drop = 1'b1;
                    end else if (SFD_EN) begin
                        state_d = PREAMBLE;
                    end else begin
                        state_d = DATA;
                        capture = 1'b1;
                    end
                end
            end
            PREAMBLE: begin
                if (!crs_dv) begin
                    state_d = IDLE;
                end else if (rx_d == 2'b11 && pre_cnt == 2'd3) begin
                    state_d = DATA;
                end else if (rx_d != 2'b01 && rx_d != 2'b00) begin
                    state_d = DROP;
                end
            end
            DATA: begin
                if (!crs_dv) begin
                    state_d    = IDLE;
                    term_now   = 1'b1;
                    push_req   = 1'b1;
                    push_data  = sr;
                    push_bytes = BW'(cnt >> 2);
                    push_last  = 1'b1;
                    push_err   = frame_err || (cnt[1:0] != 2'b00);
                end else begin
                    capture = 1'b1;
                end
            end
            DROP: begin
                if (!crs_dv) begin
                    state_d     = IDLE;
                    set_pending = in_frame;
                end
            end
            default: state_d = IDLE;
        endcase

        if (capture && cnt == CNT_LAST) begin
            word_done  = 1'b1;
            push_req   = 1'b1;
            push_data  = {sr[WORD_W-3:0], rx_d};
            push_bytes = FULL_BYTES;
            push_last  = 1'b0;
            push_err   = 1'b0;
        end

        // A pop in the same cycle frees the slot being written.
        accept = push_req && ((level < DEPTH_L) || pop);
        reject = push_req && !accept;

        if (word_done && reject) state_d = DROP;
        if (term_now && reject) set_pending = 1'b1;
    end

    // A deferred terminator waiting for space is not a dropped push.
    assign ovf_set = (reject && !pending_term) || start_drop;

    always_ff @(posedge clk_25_mhz or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            crs_dv_q     <= 1'b1;
            pre_cnt      <= 2'd0;
            sr           <= '0;
            cnt          <= '0;
            frame_err    <= 1'b0;
            in_frame     <= 1'b0;
            pending_term <= 1'b0;
            overflow     <= 1'b0;
            frame_cnt    <= 16'd0;
        end else begin
            state_q  <= state_d;
            crs_dv_q <= crs_dv;

            if (state_q == PREAMBLE && crs_dv && rx_d == 2'b01 && pre_cnt != 2'd3)
                pre_cnt <= pre_cnt + 2'd1;
            else if (state_q != PREAMBLE)
                pre_cnt <= 2'd0;

            if (capture && !word_done) begin
                sr  <= {sr[WORD_W-3:0], rx_d};
                cnt <= cnt + CW'(1);
            end else begin
                sr  <= '0;
                cnt <= '0;
            end

            if (state_q != DATA)
                frame_err <= capture && rx_er;
            else
                frame_err <= frame_err || (capture && rx_er) || (word_done && reject);

            if (state_d == DATA)
                in_frame <= 1'b1;
            else if (state_d == IDLE)
                in_frame <= 1'b0;

            if (set_pending)
                pending_term <= 1'b1;
            else if (pending_term && accept)
                pending_term <= 1'b0;

            if (ovf_set)
                overflow <= 1'b1;
            else if (ovf_clr)
                overflow <= 1'b0;

            if (accept && push_last)
                frame_cnt <= frame_cnt + 16'd1;
        end
    end

    always_ff @(posedge clk_25_mhz or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (accept) wr_ptr <= wr_ptr + AW'(1);
            if (pop)    rd_ptr <= rd_ptr + AW'(1);
            case ({accept, pop})
                2'b10:   level <= level + LW'(1);
                2'b01:   level <= level - LW'(1);
                default: level <= level;
            endcase
        end
    end

    always_ff @(posedge clk_25_mhz) begin
        if (accept) begin
            mem_data[wr_ptr]  <= push_data;
            mem_bytes[wr_ptr] <= push_bytes;
            mem_last[wr_ptr]  <= push_last;
            mem_err[wr_ptr]   <= push_err;
        end
    end

    assign rd.rd_valid = valid;
    assign rd.rd_data  = valid ? mem_data[rd_ptr]  : '0;
    assign rd.rd_bytes = valid ? mem_bytes[rd_ptr] : '0;
    assign rd.rd_last  = valid ? mem_last[rd_ptr]  : 1'b0;
    assign rd.rd_err   = valid ? mem_err[rd_ptr]   : 1'b0;

    assign fifo_level       = level;
    assign dbg_state        = state_q;
    assign dbg_pending_term = pending_term;
endmodule

// File: tb/tb_rmii_rx_fifo.sv
// Bench for rmii_rx_fifo: a raw-capture instance (DEPTH=4) and an SFD-hunting instance
// (DEPTH=8), directed scenarios plus random frames scored against a frame-level model.
module tb_rmii_rx_fifo;
    localparam int W  = 32;
    localparam int BW = 3;
    localparam int EW = W + BW + 2;

    logic clk_25_mhz = 1'b0;
    always #20 clk_25_mhz = ~clk_25_mhz;

    logic        rst_n;
    logic [3:0]  rx_d_v;
    logic [1:0]  crs_dv_v, rx_er_v, ovf_clr_v, ready_set;
    logic        rand_ready;

    logic [2:0]  fifo_level0;
    logic [3:0]  fifo_level1;
    logic        overflow0, overflow1, dbg_pend0, dbg_pend1;
    logic [15:0] frame_cnt0, frame_cnt1;
    logic [1:0]  dbg_state0, dbg_state1;

    logic [1:0]    fr_q[$];
    logic [EW-1:0] exp_q0[$];
    logic [EW-1:0] exp_q1[$];
    logic [EW-1:0] got0, got1;
    int exp_frames0, exp_frames1;
    int n_checks, n_fail;

    rmii_rx_fifo_if #(.WORD_W(W)) rd_if0 ();
    rmii_rx_fifo_if #(.WORD_W(W)) rd_if1 ();

    rmii_rx_fifo #(.WORD_W(W), .DEPTH(4), .SFD_EN(1'b0)) u_raw (
        .clk_25_mhz(clk_25_mhz), .rst_n(rst_n), .rx_d(rx_d_v[1:0]),
        .crs_dv(crs_dv_v[0]), .rx_er(rx_er_v[0]), .rd(rd_if0),
        .fifo_level(fifo_level0), .overflow(overflow0), .ovf_clr(ovf_clr_v[0]),
        .frame_cnt(frame_cnt0), .dbg_state(dbg_state0), .dbg_pending_term(dbg_pend0)
    );

    rmii_rx_fifo #(.WORD_W(W), .DEPTH(8), .SFD_EN(1'b1)) u_sfd (
        .clk_25_mhz(clk_25_mhz), .rst_n(rst_n), .rx_d(rx_d_v[3:2]),
        .crs_dv(crs_dv_v[1]), .rx_er(rx_er_v[1]), .rd(rd_if1),
        .fifo_level(fifo_level1), .overflow(overflow1), .ovf_clr(ovf_clr_v[1]),
        .frame_cnt(frame_cnt1), .dbg_state(dbg_state1), .dbg_pending_term(dbg_pend1)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [EW-1:0] make_entry(input logic [W-1:0] d, input logic [BW-1:0] b,
                                                 input logic l, input logic e);
        return {e, l, b, d};
    endfunction

    task automatic push_exp(input int dut, input logic [EW-1:0] e);
        if (dut == 0) exp_q0.push_back(e);
        else          exp_q1.push_back(e);
    endtask

    function automatic int qsize(input int dut);
        return (dut == 0) ? exp_q0.size() : exp_q1.size();
    endfunction

    // Frame-level model: every 16 dibits make a full word, the remainder forms the terminator.
    task automatic expect_frame(input int dut, input bit er);
        int n, full, rem;
        logic [W-1:0] w;
        n    = fr_q.size();
        full = n / 16;
        rem  = n % 16;
        for (int j = 0; j < full; j++) begin
            w = '0;
            for (int i = 0; i < 16; i++) w[2*(15-i) +: 2] = fr_q[16*j + i];
            push_exp(dut, make_entry(w, 3'd4, 1'b0, 1'b0));
        end
        w = '0;
        for (int i = 0; i < rem; i++) w[2*(rem-1-i) +: 2] = fr_q[16*full + i];
        push_exp(dut, make_entry(w, 3'(rem / 4), 1'b1, (rem % 4 != 0) || er));
        if (dut == 0) exp_frames0++;
        else          exp_frames1++;
    endtask

    task automatic tick();
        @(posedge clk_25_mhz);
        #1;
    endtask

    task automatic drive(input int dut, input logic [1:0] d, input logic er);
        rx_d_v[dut*2 +: 2] = d;
        crs_dv_v[dut]      = 1'b1;
        rx_er_v[dut]       = er;
        tick();
    endtask

    task automatic idle(input int dut, input int n);
        rx_d_v[dut*2 +: 2] = 2'b00;
        crs_dv_v[dut]      = 1'b0;
        rx_er_v[dut]       = 1'b0;
        repeat (n) tick();
    endtask

    task automatic load_word(input logic [W-1:0] w);
        for (int i = 15; i >= 0; i--) fr_q.push_back(w[2*i +: 2]);
    endtask

    task automatic load_random(input int n);
        for (int i = 0; i < n; i++) fr_q.push_back(2'($urandom_range(0, 3)));
    endtask

    task automatic send_frame(input int dut, input int pre, input int er_pos, input bit do_end);
        if (pre > 0) begin
            repeat (pre) drive(dut, 2'b01, 1'b0);
            drive(dut, 2'b11, 1'b0);
        end
        foreach (fr_q[i]) drive(dut, fr_q[i], i == er_pos);
        if (do_end) idle(dut, 3);
    endtask

    task automatic wait_drain(input int dut, input string tag, input int budget);
        for (int i = 0; i < budget; i++) begin
            if (qsize(dut) == 0) break;
            tick();
        end
        check(tag, 64'(qsize(dut)), 64'd0);
        repeat (2) tick();
    endtask

    always @(posedge clk_25_mhz) begin
        #2;
        rd_if0.rd_ready = rand_ready ? ($urandom_range(0, 3) != 0) : ready_set[0];
        rd_if1.rd_ready = rand_ready ? ($urandom_range(0, 3) != 0) : ready_set[1];
    end

    // Scoreboards: every popped head entry must match the front of the expected queue.
    always @(negedge clk_25_mhz) begin
        got0 = {rd_if0.rd_err & rd_if0.rd_last, rd_if0.rd_last, rd_if0.rd_bytes, rd_if0.rd_data};
        if (rd_if0.rd_valid === 1'b1 && rd_if0.rd_ready === 1'b1) begin
            if (exp_q0.size() == 0) check("raw_extra_pop", 64'(got0), 64'd0);
            else                    check("raw_entry", 64'(got0), 64'(exp_q0.pop_front()));
        end else if (rd_if0.rd_valid === 1'b0) begin
            check("raw_data_when_empty", 64'(rd_if0.rd_data), 64'd0);
        end
    end

    always @(negedge clk_25_mhz) begin
        got1 = {rd_if1.rd_err & rd_if1.rd_last, rd_if1.rd_last, rd_if1.rd_bytes, rd_if1.rd_data};
        if (rd_if1.rd_valid === 1'b1 && rd_if1.rd_ready === 1'b1) begin
            if (exp_q1.size() == 0) check("sfd_extra_pop", 64'(got1), 64'd0);
            else                    check("sfd_entry", 64'(got1), 64'(exp_q1.pop_front()));
        end else if (rd_if1.rd_valid === 1'b0) begin
            check("sfd_data_when_empty", 64'(rd_if1.rd_data), 64'd0);
        end
    end

    initial begin
        int n, er_pos, dut;
        n_checks = 0; n_fail = 0; exp_frames0 = 0; exp_frames1 = 0;
        rst_n = 1'b0; rx_d_v = '0; crs_dv_v = '0; rx_er_v = '0; ovf_clr_v = '0;
        ready_set = 2'b11; rand_ready = 1'b0;
        repeat (3) @(posedge clk_25_mhz);
        #1;
        check("rst_level0", 64'(fifo_level0), 64'd0);
        check("rst_level1", 64'(fifo_level1), 64'd0);
        check("rst_valid0", 64'(rd_if0.rd_valid), 64'd0);
        check("rst_ovf0", 64'(overflow0), 64'd0);
        check("rst_fcnt1", 64'(frame_cnt1), 64'd0);
        check("rst_state1", 64'(dbg_state1), 64'd0);
        @(negedge clk_25_mhz);
        rst_n = 1'b1;
        tick();

        // Raw one-word frame, with first-write latency observed on rd_valid.
        fr_q.delete();
        load_word(32'h9229C2C3);
        expect_frame(0, 1'b0);
        for (int i = 0; i < 16; i++) begin
            drive(0, fr_q[i], 1'b0);
            if (i == 14) check("raw_valid_before_fill", 64'(rd_if0.rd_valid), 64'd0);
            if (i == 15) check("raw_valid_after_fill", 64'(rd_if0.rd_valid), 64'd1);
        end
        idle(0, 3);
        wait_drain(0, "raw_word_drain", 40);
        check("raw_word_fcnt", 64'(frame_cnt0), 64'(exp_frames0));

        // SFD frame: long preamble, one word, then a one-byte tail.
        fr_q.delete();
        load_word(32'h4F524860);
        fr_q.push_back(2'b10); fr_q.push_back(2'b10);
        fr_q.push_back(2'b01); fr_q.push_back(2'b01);
        expect_frame(1, 1'b0);
        send_frame(1, 31, -1, 1'b1);
        wait_drain(1, "sfd_tail_drain", 40);
        check("sfd_tail_fcnt", 64'(frame_cnt1), 64'(exp_frames1));

        // Misaligned short frame.
        fr_q = '{2'b11, 2'b10, 2'b01, 2'b00, 2'b11, 2'b11};
        expect_frame(0, 1'b0);
        send_frame(0, 0, -1, 1'b1);
        wait_drain(0, "raw_short_drain", 40);

        // rx_er mid-word in a two-word frame.
        fr_q.delete();
        load_random(32);
        expect_frame(0, 1'b1);
        send_frame(0, 0, 7, 1'b1);
        wait_drain(0, "raw_rxer_drain", 40);

        // Corrupted preamble: nothing is written.
        drive(1, 2'b01, 1'b0);
        drive(1, 2'b01, 1'b0);
        drive(1, 2'b10, 1'b0);
        check("bad_pre_state", 64'(dbg_state1), 64'd3);
        drive(1, 2'b11, 1'b0);
        idle(1, 3);
        check("bad_pre_fcnt", 64'(frame_cnt1), 64'(exp_frames1));
        check("bad_pre_level", 64'(fifo_level1), 64'd0);

        // Overflow on the DEPTH=4 instance with the consumer stalled.
        ready_set[0] = 1'b0;
        fr_q.delete();
        load_random(96);
        for (int j = 0; j < 4; j++) begin
            logic [W-1:0] w;
            for (int i = 0; i < 16; i++) w[2*(15-i) +: 2] = fr_q[16*j + i];
            push_exp(0, make_entry(w, 3'd4, 1'b0, 1'b0));
        end
        push_exp(0, make_entry('0, 3'd0, 1'b1, 1'b1));
        exp_frames0++;
        send_frame(0, 0, -1, 1'b1);
        check("ovf_level", 64'(fifo_level0), 64'd4);
        check("ovf_flag", 64'(overflow0), 64'd1);
        check("ovf_pending", 64'(dbg_pend0), 64'd1);
        drive(0, 2'b01, 1'b0);
        check("pend_start_drop", 64'(dbg_state0), 64'd3);
        repeat (7) drive(0, 2'b10, 1'b0);
        idle(0, 3);
        check("pend_drop_level", 64'(fifo_level0), 64'd4);
        ready_set[0] = 1'b1;
        wait_drain(0, "ovf_drain", 40);
        check("ovf_fcnt", 64'(frame_cnt0), 64'(exp_frames0));
        check("ovf_pending_clear", 64'(dbg_pend0), 64'd0);
        check("ovf_sticky", 64'(overflow0), 64'd1);
        ovf_clr_v[0] = 1'b1;
        tick();
        ovf_clr_v[0] = 1'b0;
        check("ovf_cleared", 64'(overflow0), 64'd0);

        // Random frames on both instances with a randomly stalling consumer.
        rand_ready = 1'b1;
        for (int f = 0; f < 24; f++) begin
            dut = f % 2;
            n = $urandom_range(1, 70);
            fr_q.delete();
            load_random(n);
            er_pos = ($urandom_range(0, 3) == 0) ? $urandom_range(0, n - 1) : -1;
            expect_frame(dut, er_pos >= 0);
            send_frame(dut, (dut == 1) ? $urandom_range(4, 24) : 0, er_pos, 1'b1);
        end
        rand_ready = 1'b0;
        ready_set  = 2'b11;
        wait_drain(0, "rand_drain0", 200);
        wait_drain(1, "rand_drain1", 200);
        check("rand_fcnt0", 64'(frame_cnt0), 64'(exp_frames0));
        check("rand_fcnt1", 64'(frame_cnt1), 64'(exp_frames1));
        check("rand_ovf0", 64'(overflow0), 64'd0);
        check("rand_ovf1", 64'(overflow1), 64'd0);

        // Asynchronous reset in the middle of a frame with three words buffered.
        ready_set[0] = 1'b0;
        fr_q.delete();
        load_random(56);
        send_frame(0, 0, -1, 1'b0);
        check("mid_level_before_rst", 64'(fifo_level0), 64'd3);
        #5;
        rst_n = 1'b0;
        crs_dv_v = '0;
        #1;
        check("arst_level", 64'(fifo_level0), 64'd0);
        check("arst_valid", 64'(rd_if0.rd_valid), 64'd0);
        check("arst_data", 64'(rd_if0.rd_data), 64'd0);
        check("arst_fcnt", 64'(frame_cnt0), 64'd0);
        check("arst_state", 64'(dbg_state0), 64'd0);
        exp_q0.delete(); exp_q1.delete();
        exp_frames0 = 0; exp_frames1 = 0;
        ready_set[0] = 1'b1;
        repeat (2) @(posedge clk_25_mhz);
        @(negedge clk_25_mhz);
        rst_n = 1'b1;
        tick();
        fr_q.delete();
        load_random(20);
        expect_frame(0, 1'b0);
        send_frame(0, 0, -1, 1'b1);
        wait_drain(0, "post_rst_drain", 40);
        check("post_rst_fcnt", 64'(frame_cnt0), 64'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/rmii_rx_fifo.md
Name: rmii_rx_fifo

Overview:
Parametrised RMII receive path that replaces the fixed 32-bit rx_buf/rx_full capture with a framed, buffered word stream. Deserialises RMII dibits into WORD_W-bit words. Optionally hunts the preamble/SFD before capture. Writes words plus frame-end and error tags into a DEPTH-entry show-ahead FIFO read with a valid/ready handshake. Sits between the RMII pins and the ethernet core's receive consumer.

Parameters:
WORD_W, 32, output word width; multiple of 8, range 8..64
DEPTH, 8, FIFO entries; power of 2, ≥2
SFD_EN, 1, 1 = wait for preamble+SFD before capture; 0 = raw capture from the first crs_dv-high cycle

Ports:
clk_25_mhz  in  1  sole clock, rising edge
rst_n  in  1  asynchronous active-low reset
rx_d  in  2  RMII receive dibit
crs_dv  in  1  carrier sense / data valid
rx_er  in  1  receive error
rd_data  out  WORD_W  head entry data; 0 when rd_valid=0
rd_bytes  out  $clog2(WORD_W/8+1)  valid bytes in rd_data
rd_last  out  1  head entry ends the frame
rd_err  out  1  frame error tag; meaningful only with rd_last
rd_valid  out  1  FIFO not empty
rd_ready  in  1  consumer pops the head entry when rd_valid&&rd_ready
fifo_level  out  $clog2(DEPTH+1)  occupied entries
overflow  out  1  sticky; set on any dropped push
ovf_clr  in  1  clears overflow; a same-cycle set wins
frame_cnt  out  16  terminators written; wraps at 2^16

Behaviour:
- Reset: all outputs 0, FIFO empty, pointers 0, FSM=IDLE, pending_term=0. Reset mid-frame discards the frame. Capture restarts only on the next crs_dv rising edge seen from IDLE.
- FSM states: IDLE, PREAMBLE, DATA, DROP.
- IDLE: on crs_dv=1, go to PREAMBLE if SFD_EN=1. If SFD_EN=0, go to DATA and that cycle's rx_d is the first data dibit.
- PREAMBLE:
  - dibit 01 increments a saturating counter.
  - dibit 11 with count≥3 → DATA; the next dibit is the first data dibit.
  - dibit 00 holds.
  - any other dibit → DROP.
  - crs_dv=0 → IDLE; nothing written.
- DATA: shift register, shifts left: sr <= {sr[WORD_W-3:0], rx_d]. The first dibit ends up in [WORD_W-1:WORD_W-2].
- Word fill: after WORD_W/2 dibits, the word is written at the same edge that samples the final dibit. Tags: last=0, bytes=WORD_W/8. rd_valid rises in the following cycle when the FIFO was empty.
- Frame end: crs_dv=0 sampled in DATA → exactly one terminator write at that edge, then IDLE.
  - Partial word (n dibits, 0<n<WORD_W/2): data right-aligned, upper bits 0, bytes=floor(n/4), last=1.
  - n=0: data 0, bytes=0, last=1.
  - err=1 if n mod 4 ≠ 0 (alignment), if rx_er was seen in this frame, or if an overflow occurred in this frame.
- rx_er=1 in DATA: sets the frame error flag; capture continues.
- Accept rule: a write is accepted if level<DEPTH, or if a pop occurs in the same cycle. Simultaneous push+pop leaves the level unchanged.
- Rejected data write: set overflow, set the frame error flag, go to DROP.
- DROP: ignore dibits until crs_dv=0.
  - If the frame had reached DATA, set pending_term on the crs_dv=0 edge.
  - Corrupted preamble: nothing is written.
- pending_term:
  - Write the terminator (data 0, bytes 0, last=1, err=1) at the first edge where the accept rule holds, then clear pending_term.
  - A frame starting while pending_term=1 is dropped entirely: DROP, no terminator, overflow set.
- Rejected terminator write: same as pending_term handling.
- frame_cnt increments on every terminator actually written.
- Pointers wrap modulo DEPTH. A pop with rd_valid=0 is ignored. Popping the last entry drops rd_valid in the next cycle.

Test Plan:
- SFD_EN=0, WORD_W=32, rd_ready=1: 16 dibits of 32'h9229C2C3 (MSB dibit first), then crs_dv=0 → two entries: {9229C2C3, bytes=4, last=0} then {0, bytes=0, last=1, err=0}; frame_cnt=1.
- SFD_EN=1: 28×01, then 01,01,01,11, then 16 dibits of 32'h4F524860, then 10,10,01,01, then crs_dv=0 → {4F524860, last=0}, then {000000A5, bytes=1, last=1, err=0}.
- SFD_EN=0: 6 dibits 11,10,01,00,11,11, then crs_dv=0 → single entry {00000E4F, bytes=1, last=1, err=1}.
- rx_er pulsed one cycle mid-word in a 2-word frame → both words stored; terminator err=1.
- DEPTH=4, rd_ready=0, SFD_EN=0: frame of 6 words → level=4, overflow=1, pending_term=1. Then rd_ready=1 → 4 words read, then terminator {last=1, err=1}. ovf_clr → overflow=0.
- Preamble 01,01,10 → no writes, frame_cnt unchanged. Separately, rst_n low mid-DATA with level=3 → all outputs 0 and level 0 immediately (asynchronous); the next frame is captured cleanly.
